// File: rtl/router_pkg.sv
// Shared types and defaults for the router output-port arbiter.
package router_pkg;

  localparam int unsigned NportDefault   = 16;
  localparam int unsigned TimeoutDefault = 1024;

  typedef enum logic [1:0] {
    StIdle,
    StOwn,
    StGap
  } arb_state_e;

endpackage

// File: rtl/router_port_arb_if.sv
// Request/grant bundle between the input ports and one output-port arbiter.
interface router_port_arb_if
  import router_pkg::*;
#(
  parameter int unsigned NPORT = NportDefault
);
  localparam int unsigned IdxW = (NPORT > 1) ? $clog2(NPORT) : 1;

  logic [NPORT-1:0] req;
  logic [NPORT-1:0] eop;
  logic [NPORT-1:0] gnt;
  logic [IdxW-1:0]  gnt_id;
  logic             gnt_vld;
  logic [NPORT-1:0] busy_n;
  logic             timeout_err;

  modport master (
    output req, eop,
    input  gnt, gnt_id, gnt_vld, busy_n, timeout_err
  );

  modport slave (
    input  req, eop,
    output gnt, gnt_id, gnt_vld, busy_n, timeout_err
  );
endinterface

// File: rtl/router_port_arb_rr_pick.sv
// Combinational round-robin select: first requester at or after ptr_i, wrapping.
module rr_pick #(
  parameter int unsigned  NPORT = 16,
  localparam int unsigned IdxW  = (NPORT > 1) ? $clog2(NPORT) : 1
) (
  input  logic [NPORT-1:0] req_i,
  input  logic [IdxW-1:0]  ptr_i,
  output logic [NPORT-1:0] gnt_oh_o,
  output logic [IdxW-1:0]  gnt_idx_o
);

  logic found;

  always_comb begin
    gnt_oh_o  = '0;
    gnt_idx_o = '0;
    found     = 1'b0;
    for (int unsigned i = 0; i < NPORT; i++) begin
      int unsigned     j;
      logic [IdxW-1:0] k;
      j = 32'(ptr_i) + i;
      if (j >= NPORT) j = j - NPORT;
      k = IdxW'(j);
      if (!found && req_i[k]) begin
        found       = 1'b1;
        gnt_oh_o[k] = 1'b1;
        gnt_idx_o   = k;
      end
    end
  end

endmodule

// File: rtl/router_port_arb.sv
// Frame-level round-robin arbiter for one router output port with grant timeout.
module router_port_arb
  import router_pkg::*;
#(
  parameter int unsigned NPORT   = NportDefault,
  parameter int unsigned TIMEOUT = TimeoutDefault
) (
  input  logic              clk,
  input  logic              reset_n,
  router_port_arb_if.slave  bus
);

  localparam int unsigned IdxW = (NPORT > 1) ? $clog2(NPORT) : 1;
  localparam int unsigned CntW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(NPORT - 1);

  arb_state_e       state_q, state_d;
  logic [NPORT-1:0] gnt_q, gnt_d;
  logic [IdxW-1:0]  gnt_id_q, gnt_id_d;
  logic [IdxW-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             tout_q, tout_d;

  logic [NPORT-1:0] pick_oh;
  logic [IdxW-1:0]  pick_idx;

  rr_pick #(
    .NPORT (NPORT)
  ) u_rr_pick (
    .req_i     (bus.req),
    .ptr_i     (rr_ptr_q),
    .gnt_oh_o  (pick_oh),
    .gnt_idx_o (pick_idx)
  );

  always_comb begin
    state_d  = state_q;
    gnt_d    = gnt_q;
    gnt_id_d = gnt_id_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    tout_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (|bus.req) begin
          state_d  = StOwn;
          gnt_d    = pick_oh;
          gnt_id_d = pick_idx;
          cnt_d    = '0;
        end
      end
      StOwn: begin
        // A dropped request is a release, same as eop; eop beats timeout.
        if (bus.eop[gnt_id_q] || !bus.req[gnt_id_q] || (cnt_q == CntLast)) begin
          tout_d   = bus.req[gnt_id_q] && !bus.eop[gnt_id_q];
          state_d  = StGap;
          gnt_d    = '0;
          gnt_id_d = '0;
          rr_ptr_d = (gnt_id_q == IdxLast) ? '0 : gnt_id_q + 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StGap: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        gnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      gnt_q    <= '0;
      gnt_id_q <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      tout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gnt_q    <= gnt_d;
      gnt_id_q <= gnt_id_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      tout_q   <= tout_d;
    end
  end

  assign bus.gnt         = gnt_q;
  assign bus.gnt_id      = gnt_id_q;
  assign bus.gnt_vld     = (state_q == StOwn);
  assign bus.timeout_err = tout_q;
  assign bus.busy_n      = ~(bus.req & ~gnt_q);

endmodule

// File: tb/tb_router_port_arb.sv
// Directed-vector bench for router_port_arb with a short timeout.
module tb_router_port_arb;

  localparam int unsigned NPORT   = 16;
  localparam int unsigned TIMEOUT = 8;

  logic clk;
  logic reset_n;
  int   n_vec;
  int   n_err;

  router_port_arb_if #(.NPORT(NPORT)) bus ();

  router_port_arb #(
    .NPORT   (NPORT),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_gnt(input string tag, input logic [15:0] g, input logic [3:0] id,
                           input logic vld, input logic tout);
    check({tag, ".gnt"},     32'(bus.gnt),         32'(g));
    check({tag, ".gnt_id"},  32'(bus.gnt_id),      32'(id));
    check({tag, ".gnt_vld"}, 32'(bus.gnt_vld),     32'(vld));
    check({tag, ".tout"},    32'(bus.timeout_err), 32'(tout));
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    reset_n = 1'b0;
    bus.req = '0;
    bus.eop = '0;
    #12;
    check_gnt("rst", 16'h0000, 4'd0, 1'b0, 1'b0);
    check("rst.busy_n", 32'(bus.busy_n), 32'hffff);
    reset_n = 1'b1;
    tick();
    tick();
    check_gnt("idle_noreq", 16'h0000, 4'd0, 1'b0, 1'b0);

    // Single requester, frame ends with eop
    bus.req = 16'h0001;
    tick();
    check_gnt("p0_own", 16'h0001, 4'd0, 1'b1, 1'b0);
    bus.eop = 16'h0001;
    tick();
    check_gnt("p0_gap", 16'h0000, 4'd0, 1'b0, 1'b0);
    bus.eop = '0;
    bus.req = '0;
    tick();
    check_gnt("p0_idle", 16'h0000, 4'd0, 1'b0, 1'b0);

    // Re-reset so the pointer starts at 0, then alternate 0 and 15
    reset_n = 1'b0;
    #3;
    reset_n = 1'b1;
    bus.req = 16'h8001;
    tick();
    check_gnt("rr_a", 16'h0001, 4'd0, 1'b1, 1'b0);
    check("rr_a.busy_n", 32'(bus.busy_n), 32'h7fff);
    bus.eop = 16'h0001;
    tick();
    check_gnt("rr_a_gap", 16'h0000, 4'd0, 1'b0, 1'b0);
    bus.eop = '0;
    tick();
    check_gnt("rr_a_idle", 16'h0000, 4'd0, 1'b0, 1'b0);
    tick();
    check_gnt("rr_b", 16'h8000, 4'd15, 1'b1, 1'b0);
    check("rr_b.busy_n", 32'(bus.busy_n), 32'hfffe);
    bus.eop = 16'h8000;
    tick();
    check_gnt("rr_b_gap", 16'h0000, 4'd0, 1'b0, 1'b0);
    bus.eop = '0;
    tick();
    tick();
    check_gnt("rr_c", 16'h0001, 4'd0, 1'b1, 1'b0);
    bus.req = '0;
    tick();
    check_gnt("rr_c_drop", 16'h0000, 4'd0, 1'b0, 1'b0);
    tick();

    // Timeout: port 2 holds past TIMEOUT cycles with no eop
    bus.req = 16'h0004;
    for (int k = 1; k <= 8; k++) begin
      tick();
      check_gnt($sformatf("to_own%0d", k), 16'h0004, 4'd2, 1'b1, 1'b0);
    end
    tick();
    check_gnt("to_revoke", 16'h0000, 4'd0, 1'b0, 1'b1);
    bus.req = 16'h000c;
    tick();
    check_gnt("to_idle", 16'h0000, 4'd0, 1'b0, 1'b0);
    tick();
    check_gnt("to_next", 16'h0008, 4'd3, 1'b1, 1'b0);

    // Owner 3: foreign eop ignored, request drop releases
    bus.req = 16'h002c;
    bus.eop = 16'h0020;
    tick();
    check_gnt("eop5_ign", 16'h0008, 4'd3, 1'b1, 1'b0);
    bus.eop = '0;
    tick();
    check_gnt("eop5_hold", 16'h0008, 4'd3, 1'b1, 1'b0);
    bus.req = 16'h0024;
    tick();
    check_gnt("drop3", 16'h0000, 4'd0, 1'b0, 1'b0);
    tick();
    tick();
    check_gnt("after3", 16'h0020, 4'd5, 1'b1, 1'b0);

    // Asynchronous reset mid-frame
    reset_n = 1'b0;
    #1;
    check_gnt("arst", 16'h0000, 4'd0, 1'b0, 1'b0);
    bus.req = 16'h0300;
    #2;
    reset_n = 1'b1;
    tick();
    check_gnt("arst_next", 16'h0100, 4'd8, 1'b1, 1'b0);

    // eop on the last allowed cycle beats the timeout
    for (int k = 2; k <= 8; k++) begin
      tick();
      check_gnt($sformatf("eopw_own%0d", k), 16'h0100, 4'd8, 1'b1, 1'b0);
    end
    bus.eop = 16'h0100;
    tick();
    check_gnt("eopw_rel", 16'h0000, 4'd0, 1'b0, 1'b0);
    bus.eop = '0;
    bus.req = '0;
    tick();
    check_gnt("eopw_idle", 16'h0000, 4'd0, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/router_port_arb.md
ROUTER_PORT_ARB -- requirements
Module: router_port_arb

Interface
REQ-001 SHALL have parameter NPORT, default 16, number of requesting input ports.
REQ-002 SHALL have parameter TIMEOUT, default 1024, maximum cycles a grant is held.
REQ-003 SHALL have port clk  input  1  single clock; all logic on posedge.
REQ-004 SHALL have port reset_n  input  1  asynchronous active-low reset.
REQ-005 SHALL have port req  input  NPORT  per-input level request for this output port; held until frame end.
REQ-006 SHALL have port eop  input  NPORT  per-input one-cycle pulse marking the last cycle of a frame.
REQ-007 SHALL have port gnt  output  NPORT  one-hot registered grant; all-zero when no owner.
REQ-008 SHALL have port gnt_id  output  4  index of current owner; 0 when none.
REQ-009 SHALL have port gnt_vld  output  1  high while any grant is held.
REQ-010 SHALL have port busy_n  output  NPORT  active-low; bit i low when req[i] high and gnt[i] low.
REQ-011 SHALL have port timeout_err  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-012 SHALL implement states IDLE, OWN, GAP.
REQ-013 IDLE: if any req bit high, SHALL select the first requester at or after rr_ptr (wrapping NPORT-1 -> 0), enter OWN, and assert gnt one cycle after req is sampled.
REQ-014 IDLE with req all-zero SHALL remain IDLE with gnt=0.
REQ-015 OWN: gnt and gnt_id SHALL hold constant; new requests SHALL NOT pre-empt the owner.
REQ-016 OWN: eop[owner]=1 SHALL clear gnt on the next edge and enter GAP.
REQ-017 OWN: req[owner] falling without eop SHALL be treated as release (as REQ-016), no error.
REQ-018 eop on non-owner inputs SHALL be ignored.
REQ-019 Hold counter SHALL reset to 0 on entry to OWN and increment each OWN cycle; at count TIMEOUT-1 without eop, gnt SHALL clear on the next edge, timeout_err SHALL pulse in that same cycle, and the state SHALL become GAP.
REQ-020 eop[owner] and timeout in the same cycle: eop SHALL win, no timeout_err.
REQ-021 On leaving OWN, rr_ptr SHALL become (owner+1) mod NPORT.
REQ-022 GAP SHALL last exactly one cycle with gnt=0 (inter-frame idle), then go to IDLE.
REQ-023 busy_n SHALL be combinational from req and registered gnt; busy_n[i]=1 when req[i]=0.
REQ-024 Hold counter width SHALL be clog2(TIMEOUT); counter SHALL NOT wrap within OWN.

Reset
REQ-025 reset_n low SHALL asynchronously force state=IDLE, gnt=0, gnt_id=0, gnt_vld=0, timeout_err=0, rr_ptr=0, counter=0.
REQ-026 Reset asserted mid-OWN SHALL drop the grant immediately with no timeout_err; first arbitration after release SHALL start from port 0.

Structure
REQ-027 State enum, NPORT default, and TIMEOUT default SHALL live in shared package router_pkg.
REQ-028 Round-robin priority select SHALL be one sub-module, rr_pick (inputs req, ptr; output one-hot and index), combinational.
REQ-029 One router_port_arb instance SHALL exist per router output port.

Verification
REQ-030 Reset, req=0x0001 -> gnt=0x0001, gnt_id=0 one cycle later; eop[0] -> gnt=0 next cycle, one GAP cycle.
REQ-031 req=0x8001 held, rr_ptr=0 -> grants in order port 0, port 15, port 0, each separated by one GAP cycle; busy_n[15]=0 while port 0 owns.
REQ-032 TIMEOUT=8, owner never sends eop -> gnt clears after 8 OWN cycles, timeout_err one-cycle pulse, rr_ptr=owner+1.
REQ-033 TIMEOUT=8, eop[owner] on 8th OWN cycle -> normal release, timeout_err stays 0.
REQ-034 Owner port 3; eop[5] pulse -> no change; req[3] drops -> release, next grant to lowest requester at or after port 4.
REQ-035 reset_n low mid-OWN -> gnt=0 asynchronously; after release, req=0x0300 -> gnt=0x0100.
